// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that reuses one full-adder cell for every bit position.
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin one addition (accepted only in IDLE)
//   a, b   - operands, latched when start is accepted
//   cin    - carry-in, latched when start is accepted
//   busy   - high while bits are being added
//   done   - one-cycle pulse when sum/cout are valid
//   sum    - result a+b+cin modulo 2^WIDTH, held until the next accepted start
//   cout   - carry-out of the full-width addition

module FA (
    output logic s,
    output logic Carry_out,
    input  logic x,
    input  logic y,
    input  logic Carry_in
);
    assign s         = x ^ y ^ Carry_in;
    assign Carry_out = (x & y) | (Carry_in & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    FA u_fa (
        .s        (fa_s),
        .Carry_out(fa_co),
        .x        (a_sr[0]),
        .y        (b_sr[0]),
        .Carry_in (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Result bits arrive LSB first, so they enter at the MSB and drift down.
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for the bit-serial adder (WIDTH=8 and WIDTH=2).
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One addition on the 8-bit DUT; inj selects the RUN cycle where a stray start is pulsed (-1: none).
    task automatic run_add(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                           input logic [7:0] es, input logic ec, input int inj);
        start = 1'b1; a = va; b = vb; cin = vc;
        step();
        chk("accept_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("run_busy", {31'd0, busy}, 32'd1);
            chk("run_done", {31'd0, done}, 32'd0);
            start = (i == inj);
            a = 8'hAA; b = 8'h55; cin = 1'b1;
            step();
        end
        start = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("sum", {24'd0, sum}, {24'd0, es});
        chk("cout", {31'd0, cout}, {31'd0, ec});
        step();
        chk("done_clear", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_done", {31'd0, done}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_hold", {23'd0, cout, sum}, {23'd0, ec, es});
        end
    endtask

    initial begin
        int gap;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        #11 rst_n = 1'b1;
        step();

        run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, -1);
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
        run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1);
        run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);

        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum", {24'd0, sum}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        run_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1);

        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
        step();
        a = 8'h7F; b = 8'h01; cin = 1'b1;
        gap = 0;
        while (!done && gap < 20) begin
            step();
            gap++;
        end
        chk("b2b_first_latency", gap, 32'd8);
        chk("b2b_first", {23'd0, cout, sum}, 32'h100);
        gap = 0;
        do begin
            step();
            gap++;
        end while (!done && gap < 20);
        start = 1'b0;
        chk("b2b_gap", gap, 32'd10);
        chk("b2b_second", {23'd0, cout, sum}, 32'h081);
        step();
        chk("b2b_end_done", {31'd0, done}, 32'd0);

        for (int v = 0; v < 32; v++) begin
            logic [4:0] vv;
            vv = 5'(v);
            a2 = vv[4:3]; b2 = vv[2:1]; cin2 = vv[0];
            start2 = 1'b1;
            step();
            start2 = 1'b0;
            step();
            chk("w2_busy", {31'd0, busy2}, 32'd1);
            step();
            chk("w2_done", {31'd0, done2}, 32'd1);
            chk("w2_result", {29'd0, cout2, sum2}, 32'(vv[4:3]) + 32'(vv[2:1]) + 32'(vv[0]));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, meaning operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 Port: cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 Port: busy  output  1  high while an addition is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 Port: sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH.
REQ-011 Port: cout  output  1  registered carry-out of the full-width addition.

Function
REQ-012 The block SHALL compute each sum bit with exactly one instance of the team's 1-bit full-adder cell FA (ports s, Carry_out, x, y, Carry_in), time-shared across all bit positions; no other adder logic is permitted.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE: start=1 on an edge SHALL latch a, b into operand shift registers, cin into the carry register, clear the bit counter to 0, and move to RUN.
REQ-015 IDLE with start=0 SHALL hold all registers, including sum and cout.
REQ-016 RUN: each edge SHALL feed FA with x=A[0], y=B[0], Carry_in=carry register; shift A and B right by one; shift FA.s into sum MSB while shifting sum right (LSB-first assembly); load FA.Carry_out into the carry register; increment the counter.
REQ-017 RUN SHALL last exactly WIDTH edges; on the edge where counter == WIDTH-1 the FSM SHALL move to DONE.
REQ-018 cout SHALL equal the carry register after the final RUN edge.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 busy SHALL be 1 in RUN, 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-021 Latency: start accepted at edge k -> done high during the cycle after edge k+WIDTH; sum/cout stable from that cycle until the next accepted start.
REQ-022 start while in RUN or DONE SHALL be ignored (no latch, no queuing); a,b,cin changes after acceptance SHALL not affect the result.
REQ-023 Back-to-back: start held high continuously SHALL be accepted on the first edge in IDLE after each DONE, i.e. one addition every WIDTH+2 cycles.
REQ-024 sum register SHALL not be cleared on start; during RUN its contents are partial and undefined to the user until done.
REQ-025 Arithmetic SHALL be unsigned: {cout,sum} == a + b + cin exactly, for all inputs.

Reset
REQ-026 rst_n=0 SHALL, without waiting for clk, force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, operand and carry registers 0.
REQ-027 Reset asserted mid-RUN SHALL abort the addition; no done pulse SHALL follow reset release.
REQ-028 After rst_n rises, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-029 WIDTH=8: a=0x5A, b=0x3C, cin=0, start 1 cycle -> busy 8 cycles, done pulse 1 cycle, sum=0x96, cout=0.
REQ-030 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 Start 0x10+0x20, then pulse start with a=0xAA, b=0x55 at RUN cycle 3 -> ignored; result sum=0x30, cout=0; exactly one done pulse.
REQ-032 Start 0x12+0x34, drop rst_n at RUN cycle 4 -> busy, sum, cout 0 immediately; no done; subsequent 0x01+0x01 -> sum=0x02.
REQ-033 start held high, operands 0x80+0x80+0 then 0x7F+0x01+1 -> done pulses 10 cycles apart; results {1,0x00} then {0,0x81}.
REQ-034 Exhaustive WIDTH=2 sweep of all 32 (a,b,cin) combinations -> {cout,sum} == a+b+cin, zero errors reported.
